i2c_target_mem: RTL and testbench

I2C_TARGET_MEM -- requirements
Module: i2c_target_mem

---
 rtl/i2c_target_mem.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_target_mem.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_mem.sv
// rtl/i2c_target_mem.sv - I2C target with a 16-byte memory; optional I2C_TGT_GLITCH_FILTER_EN majority filter
module i2c_target_mem #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       err
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic        scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        oe_q, oe_d;
    logic        wr_stb_q, wr_stb_d;
    logic        err_q, err_d;
    logic [7:0]  mem_q [16];
    logic [7:0]  mem_d [16];
    logic        scl_lvl, sda_lvl;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic        data_state, load_rd;

    // two-flop synchronizers; the previous-level flops feed edge detection
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_lvl;
        sda_prev_d = sda_lvl;
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    // 2-of-3 vote over the newest synchronized sample and the two before it
    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_filt_d = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1])
                   | (scl_hist_q[0] & scl_hist_q[1]);
        sda_filt_d = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1])
                   | (sda_hist_q[0] & sda_hist_q[1]);
    end

    // filter history registers, reset to the idle-bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_lvl = scl_filt_q;
    assign sda_lvl = sda_filt_q;
`else
    assign scl_lvl = scl_sync_q[1];
    assign sda_lvl = sda_sync_q[1];
`endif

    assign scl_rise  = scl_lvl & ~scl_prev_q;
    assign scl_fall  = ~scl_lvl & scl_prev_q;
    assign start_det = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            wr_stb_q   <= 1'b0;
            err_q      <= 1'b0;
            mem_q      <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            wr_stb_q   <= wr_stb_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
        end
    end

    // next-state logic: bit reception/transmission, ACK handling, memory commit
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        wr_stb_d   = 1'b0;
        err_d      = 1'b0;
        mem_d      = mem_q;
        load_rd    = 1'b0;
        data_state = (state_q == ADDR) || (state_q == PTR) || (state_q == WDATA) || (state_q == RDATA);

        // the committed byte sits in shift_q during the strobe cycle
        if (wr_stb_q) begin
            mem_d[ptr_q] = shift_q;
            ptr_d        = ptr_q + 4'd1;
        end

        if (start_det || stop_det) begin
            // the SCL high phase carrying START/STOP already bumped cnt, so
            // completed bits are cnt-1; only 1..7 completed bits is an error
            err_d = data_state && (cnt_q >= 4'd2) && (cnt_q <= 4'd8);
            cnt_d = '0;
            if (stop_det) begin
                state_d = IDLE;
                oe_d    = 1'b0;
            end else begin
                state_d = ADDR;
            end
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shift_d  = {shift_q[6:0], sda_lvl};
                        cnt_d    = cnt_q + 4'd1;
                        wr_stb_d = (state_q == WDATA) && (cnt_q == 4'd7);
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                                oe_d    = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d   = shift_q[3:0];
                            state_d = PTR_ACK;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = WDATA_ACK;
                            oe_d    = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            load_rd = 1'b1;
                        end else begin
                            state_d = PTR;
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = WDATA;
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                    end
                end
                RDATA: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = RACK;
                            oe_d    = 1'b0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                RACK: begin
                    // cnt = 9 marks a master ACK awaiting the falling edge
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            cnt_d = 4'd9;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && (cnt_q == 4'd9)) begin
                        load_rd = 1'b1;
                    end
                end
                default: ;
            endcase

            if (load_rd) begin
                shift_d = mem_q[ptr_q];
                ptr_d   = ptr_q + 4'd1;
                oe_d    = ~mem_q[ptr_q][7];
                cnt_d   = '0;
                state_d = RDATA;
            end
        end
    end

    // outputs
    always_comb begin
        busy    = (state_q != IDLE);
        sda_oe  = oe_q;
        wr_stb  = wr_stb_q;
        wr_addr = ptr_q;
        wr_data = shift_q;
        err     = err_q;
    end
endmodule

// File: tb/tb_i2c_target_mem.sv
// tb/tb_i2c_target_mem.sv - directed bench for i2c_target_mem
module tb_i2c_target_mem;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_i = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_i, sda_oe, busy, wr_stb, err;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         err_cnt = 0;
    logic       oe_seen = 1'b0;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;

    i2c_target_mem #(.DEV_ADDR(7'h50)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .err     (err)
    );

    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (err) err_cnt = err_cnt + 1;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic qw();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qw();
        scl_i = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_i = 1'b0; qw();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qw();
        scl_i = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; qw();
            scl_i = 1'b1;   qw();
            scl_i = 1'b0;   qw();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; qw();
        scl_i = 1'b1; qw();
        ack = ~sda_i;
        scl_i = 1'b0; qw();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        d = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; qw();
            scl_i = 1'b1; qw();
            d = {d[6:0], sda_i};
            scl_i = 1'b0; qw();
        end
        sda_m = nack; qw();
        scl_i = 1'b1; qw();
        scl_i = 1'b0; qw();
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         w0, e0;

        repeat (5) @(posedge clk);
        #1;
        chk("reset_sda_oe", sda_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wr_stb", wr_stb, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        qw();

        // write 0x5A to index 3
        w0 = wr_cnt; e0 = err_cnt;
        bus_start();
        chk("t1_busy_start", busy, 1);
        send_byte(8'hA0, ack); chk("t1_ack_addr", ack, 1);
        send_byte(8'h03, ack); chk("t1_ack_ptr", ack, 1);
        send_byte(8'h5A, ack); chk("t1_ack_data", ack, 1);
        bus_stop();
        chk("t1_wr_count", wr_cnt - w0, 1);
        chk("t1_wr_addr", last_addr, 4'h3);
        chk("t1_wr_data", last_data, 8'h5A);
        chk("t1_busy_stop", busy, 0);
        chk("t1_no_err", err_cnt - e0, 0);

        // pointer write, repeated START, read one byte with NACK
        bus_start();
        send_byte(8'hA0, ack); chk("t2_ack_addr", ack, 1);
        send_byte(8'h03, ack); chk("t2_ack_ptr", ack, 1);
        bus_start();
        send_byte(8'hA1, ack); chk("t2_ack_raddr", ack, 1);
        read_byte(1'b1, d);
        bus_stop();
        chk("t2_read_data", d, 8'h5A);
        chk("t2_ptr", dut.ptr_q, 4'h4);
        chk("t2_busy_stop", busy, 0);

        // pointer wrap 15 -> 0
        w0 = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        send_byte(8'h11, ack); chk("t3_ack_d0", ack, 1);
        send_byte(8'h22, ack); chk("t3_ack_d1", ack, 1);
        bus_stop();
        chk("t3_wr_count", wr_cnt - w0, 2);
        chk("t3_last_addr", last_addr, 4'h0);
        chk("t3_mem15", dut.mem_q[15], 8'h11);
        chk("t3_mem0", dut.mem_q[0], 8'h22);
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        bus_start();
        send_byte(8'hA1, ack);
        read_byte(1'b0, d); chk("t3_rd0", d, 8'h11);
        read_byte(1'b1, d); chk("t3_rd1", d, 8'h22);
        bus_stop();

        // address mismatch: 0x58
        w0 = wr_cnt; oe_seen = 1'b0;
        bus_start();
        send_byte(8'hB0, ack); chk("t4_nack_addr", ack, 0);
        send_byte(8'h12, ack); chk("t4_nack_byte", ack, 0);
        bus_stop();
        chk("t4_oe_never", oe_seen, 0);
        chk("t4_no_write", wr_cnt - w0, 0);
        chk("t4_state_idle", dut.state_q, 0);

        // STOP after 4 data bits
        w0 = wr_cnt; e0 = err_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        send_bits(8'hA0, 4);
        bus_stop();
        chk("t5_err_once", err_cnt - e0, 1);
        chk("t5_no_write", wr_cnt - w0, 0);
        chk("t5_state_idle", dut.state_q, 0);
        chk("t5_busy", busy, 0);
        chk("t5_mem5", dut.mem_q[5], 8'h00);

`ifdef I2C_TGT_GLITCH_FILTER_EN
        // single-cycle SDA low while SCL high must not look like START
        e0 = err_cnt;
        @(posedge clk); #1 sda_m = 1'b0;
        @(posedge clk); #1 sda_m = 1'b1;
        qw();
        chk("t6_glitch_busy", busy, 0);
        chk("t6_glitch_state", dut.state_q, 0);
`endif

        // reset while acknowledging the address
        w0 = wr_cnt;
        bus_start();
        send_bits(8'hA0, 8);
        chk("t7_oe_acking", sda_oe, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t7_oe_released", sda_oe, 0);
        chk("t7_busy", busy, 0);
        chk("t7_ptr", dut.ptr_q, 4'h0);
        chk("t7_mem3", dut.mem_q[3], 8'h00);
        rst = 1'b0;
        sda_m = 1'b1; qw();
        scl_i = 1'b1; qw();
        scl_i = 1'b0; qw();
        chk("t7_ignore_busy", busy, 0);
        chk("t7_ignore_oe", sda_oe, 0);
        chk("t7_no_write", wr_cnt - w0, 0);
        bus_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
